// File: rtl/fwgpio_in_wb.sv
// fwgpio_in_wb: input conditioning in front of the GPIO core's pin_i.
// Each pad is synchronised, debounced and edge-detected; enabled edges are
// latched into PENDING, which drives a level interrupt. A small Wishbone
// target exposes STATE, RISE_EN, FALL_EN and PENDING (write-one-to-clear).
module fwgpio_in_wb #(
    parameter int N_PINS     = 32,
    parameter int DEB_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        rt_adr,
    input  logic [31:0]       rt_dat_w,
    output logic [31:0]       rt_dat_r,
    input  logic              rt_cyc,
    input  logic              rt_stb,
    input  logic              rt_we,
    input  logic [3:0]        rt_sel,
    output logic              rt_ack,
    output logic              rt_err,
    input  logic [N_PINS-1:0] pad_i,
    output logic [N_PINS-1:0] pin_o,
    output logic              irq
);

    localparam int CW = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;

    logic [N_PINS-1:0] s1;
    logic [N_PINS-1:0] s2;
    logic [N_PINS-1:0] deb;
    logic [N_PINS-1:0] deb_next;
    logic [N_PINS-1:0] rise;
    logic [N_PINS-1:0] fall;
    logic [N_PINS-1:0] rise_en;
    logic [N_PINS-1:0] fall_en;
    logic [N_PINS-1:0] pending;
    logic [N_PINS-1:0] clr;
    logic [31:0]       byte_mask;
    logic [31:0]       rd_mux;
    logic              accept;
    logic              wr;
    logic              unused_bits;

    // Two-flop synchroniser per pad.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pad_i;
            s2 <= s1;
        end
    end

    generate
        if (DEB_CYCLES == 0) begin : g_bypass
            // No debounce: the second sync stage is the debounced value, so
            // the value it loads next is simply the first stage.
            assign deb      = s2;
            assign deb_next = s1;
        end else begin : g_deb
            logic [CW-1:0] cnt      [N_PINS];
            logic [CW-1:0] cnt_next [N_PINS];

            // Per-pin stability counter; deb only follows s2 after it has
            // differed for DEB_CYCLES consecutive cycles.
            always_comb begin
                for (int i = 0; i < N_PINS; i++) begin
                    cnt_next[i] = cnt[i];
                    deb_next[i] = deb[i];
                    if (s2[i] == deb[i]) begin
                        cnt_next[i] = '0;
                    end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                        deb_next[i] = s2[i];
                        cnt_next[i] = '0;
                    end else begin
                        cnt_next[i] = cnt[i] + CW'(1);
                    end
                end
            end

            // Debounced state and counters.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    deb <= '0;
                    for (int i = 0; i < N_PINS; i++) begin
                        cnt[i] <= '0;
                    end
                end else begin
                    deb <= deb_next;
                    for (int i = 0; i < N_PINS; i++) begin
                        cnt[i] <= cnt_next[i];
                    end
                end
            end
        end
    endgenerate

    assign pin_o = deb;
    assign rise  = deb_next & ~deb;
    assign fall  = ~deb_next & deb;

    assign accept    = rt_cyc & rt_stb & ~rt_ack;
    assign wr        = accept & rt_we;
    assign byte_mask = {{8{rt_sel[3]}}, {8{rt_sel[2]}}, {8{rt_sel[1]}}, {8{rt_sel[0]}}};
    assign clr       = (wr && rt_adr[3:2] == 2'd3) ? (rt_dat_w[N_PINS-1:0] & byte_mask[N_PINS-1:0]) : '0;

    // Register read mux; bits above N_PINS read as zero.
    always_comb begin
        rd_mux = '0;
        case (rt_adr[3:2])
            2'd0:    rd_mux[N_PINS-1:0] = deb;
            2'd1:    rd_mux[N_PINS-1:0] = rise_en;
            2'd2:    rd_mux[N_PINS-1:0] = fall_en;
            default: rd_mux[N_PINS-1:0] = pending;
        endcase
    end

    // Enable registers and pending latch; a new edge beats a same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rise_en <= '0;
            fall_en <= '0;
            pending <= '0;
        end else begin
            if (wr && rt_adr[3:2] == 2'd1) begin
                rise_en <= (rise_en & ~byte_mask[N_PINS-1:0]) | (rt_dat_w[N_PINS-1:0] & byte_mask[N_PINS-1:0]);
            end
            if (wr && rt_adr[3:2] == 2'd2) begin
                fall_en <= (fall_en & ~byte_mask[N_PINS-1:0]) | (rt_dat_w[N_PINS-1:0] & byte_mask[N_PINS-1:0]);
            end
            pending <= (pending & ~clr) | (rise & rise_en) | (fall & fall_en);
        end
    end

    // Single-cycle ack with read data captured at acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rt_ack   <= 1'b0;
            rt_dat_r <= '0;
        end else begin
            rt_ack   <= accept;
            rt_dat_r <= accept ? rd_mux : '0;
        end
    end

    assign irq         = |pending;
    assign rt_err      = 1'b0;
    assign unused_bits = ^{rt_adr[1:0], rt_dat_w, byte_mask};

endmodule

// File: tb/tb_fwgpio_in_wb.sv
// Directed bench for fwgpio_in_wb: a default build (32 pins, DEB_CYCLES=4)
// plus an 8-pin debounce-bypass build sharing clock and reset.
module tb_fwgpio_in_wb;

    logic        clock;
    logic        reset;
    logic [3:0]  rt_adr;
    logic [31:0] rt_dat_w;
    logic [31:0] rt_dat_r;
    logic        rt_cyc;
    logic        rt_stb;
    logic        rt_we;
    logic [3:0]  rt_sel;
    logic        rt_ack;
    logic        rt_err;
    logic [31:0] pad_i;
    logic [31:0] pin_o;
    logic        irq;

    logic [7:0]  pad0;
    logic [7:0]  pin_o0;
    logic [31:0] dat_r0;
    logic        ack0;
    logic        err0;
    logic        irq0;

    int n_vectors;
    int n_miscompares;
    logic [31:0] rd;

    fwgpio_in_wb #(.N_PINS(32), .DEB_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .rt_adr(rt_adr), .rt_dat_w(rt_dat_w), .rt_dat_r(rt_dat_r),
        .rt_cyc(rt_cyc), .rt_stb(rt_stb), .rt_we(rt_we), .rt_sel(rt_sel),
        .rt_ack(rt_ack), .rt_err(rt_err),
        .pad_i(pad_i), .pin_o(pin_o), .irq(irq)
    );

    fwgpio_in_wb #(.N_PINS(8), .DEB_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset),
        .rt_adr(4'h0), .rt_dat_w(32'h0), .rt_dat_r(dat_r0),
        .rt_cyc(1'b0), .rt_stb(1'b0), .rt_we(1'b0), .rt_sel(4'h0),
        .rt_ack(ack0), .rt_err(err0),
        .pad_i(pad0), .pin_o(pin_o0), .irq(irq0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors++;
        assert (observed === expected) else begin
            n_miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] adr, input logic [31:0] data, input logic [3:0] sel);
        rt_adr   = adr;
        rt_dat_w = data;
        rt_sel   = sel;
        rt_we    = 1'b1;
        rt_cyc   = 1'b1;
        rt_stb   = 1'b1;
        tick();
        check("wr_ack", {31'b0, rt_ack}, 32'h1);
        rt_cyc = 1'b0;
        rt_stb = 1'b0;
        rt_we  = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic [3:0] adr, output logic [31:0] data);
        rt_adr = adr;
        rt_sel = 4'hF;
        rt_we  = 1'b0;
        rt_cyc = 1'b1;
        rt_stb = 1'b1;
        tick();
        check("rd_ack", {31'b0, rt_ack}, 32'h1);
        data   = rt_dat_r;
        rt_cyc = 1'b0;
        rt_stb = 1'b0;
        tick();
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        reset    = 1'b1;
        pad_i    = 32'h0000_0005;
        pad0     = 8'h00;
        rt_adr   = 4'h0;
        rt_dat_w = 32'h0;
        rt_cyc   = 1'b0;
        rt_stb   = 1'b0;
        rt_we    = 1'b0;
        rt_sel   = 4'h0;
        tick();
        tick();
        check("rst_pin", pin_o, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_ack", {31'b0, rt_ack}, 32'h0);
        check("rst_dat", rt_dat_r, 32'h0);
        check("rst_err", {31'b0, rt_err}, 32'h0);

        // Pads held at 0x5 through reset release.
        reset = 1'b0;
        repeat (5) tick();
        check("rel_pin5", pin_o, 32'h0);
        tick();
        check("rel_pin6", pin_o, 32'h5);
        check("rel_irq", {31'b0, irq}, 32'h0);
        bus_read(4'hC, rd);
        check("rel_pend", rd, 32'h0);
        bus_read(4'h0, rd);
        check("rel_state", rd, 32'h5);

        // Glitch of 3 cycles must not pass.
        pad_i = 32'h0;
        repeat (8) tick();
        pad_i = 32'h1;
        repeat (3) tick();
        pad_i = 32'h0;
        repeat (3) tick();
        check("glitch_a", pin_o, 32'h0);
        repeat (5) tick();
        check("glitch_b", pin_o, 32'h0);

        // Stable high: pin follows exactly 6 clocks after the pad.
        pad_i = 32'h1;
        repeat (5) tick();
        check("hold_5", pin_o, 32'h0);
        tick();
        check("hold_6", pin_o, 32'h1);
        repeat (2) tick();

        // Rising-edge interrupt and W1C.
        bus_write(4'h4, 32'h1, 4'hF);
        pad_i = 32'h0;
        repeat (8) tick();
        bus_read(4'hC, rd);
        check("fall_noen", rd, 32'h0);
        pad_i = 32'h1;
        repeat (5) tick();
        check("irq_pre", {31'b0, irq}, 32'h0);
        tick();
        check("irq_set", {31'b0, irq}, 32'h1);
        bus_read(4'hC, rd);
        check("pend_set", rd, 32'h1);
        bus_write(4'hC, 32'h1, 4'hF);
        check("irq_clr", {31'b0, irq}, 32'h0);
        bus_read(4'hC, rd);
        check("pend_clr", rd, 32'h0);

        // Byte-enable writes to FALL_EN.
        bus_write(4'h8, 32'h2, 4'b0001);
        bus_read(4'h8, rd);
        check("fen_b0", rd, 32'h2);
        bus_write(4'h8, 32'hFFFF_FFFF, 4'b0010);
        bus_read(4'h8, rd);
        check("fen_b1", rd, 32'h0000_FF02);

        // STATE ignores writes.
        bus_write(4'h0, 32'hFFFF_FFFF, 4'hF);
        bus_read(4'h0, rd);
        check("state_ro", rd, 32'h1);

        // W1C in the same cycle as a new enabled rise: set wins.
        pad_i = 32'h0;
        repeat (8) tick();
        bus_read(4'hC, rd);
        check("sw_pre", rd, 32'h0);
        pad_i = 32'h1;
        repeat (5) tick();
        bus_write(4'hC, 32'h1, 4'hF);
        bus_read(4'hC, rd);
        check("set_wins", rd, 32'h1);
        check("set_wins_irq", {31'b0, irq}, 32'h1);

        // Clearing the enable keeps the pending bit.
        bus_write(4'h4, 32'h0, 4'hF);
        bus_read(4'hC, rd);
        check("en_off_keep", rd, 32'h1);
        bus_write(4'hC, 32'h1, 4'hF);
        bus_read(4'hC, rd);
        check("pend_clr2", rd, 32'h0);

        // Debounce bypass build: 2-clock latency.
        pad0 = 8'hA5;
        tick();
        check("byp_a1", {24'b0, pin_o0}, 32'h00);
        tick();
        check("byp_a2", {24'b0, pin_o0}, 32'hA5);
        pad0 = 8'h5A;
        tick();
        check("byp_b1", {24'b0, pin_o0}, 32'hA5);
        tick();
        check("byp_b2", {24'b0, pin_o0}, 32'h5A);

        // Reset during a read in flight.
        bus_write(4'h4, 32'h3, 4'hF);
        rt_adr = 4'h4;
        rt_we  = 1'b0;
        rt_cyc = 1'b1;
        rt_stb = 1'b1;
        tick();
        check("inflt_ack", {31'b0, rt_ack}, 32'h1);
        check("inflt_dat", rt_dat_r, 32'h3);
        #1 reset = 1'b1;
        #1;
        check("arst_ack", {31'b0, rt_ack}, 32'h0);
        check("arst_dat", rt_dat_r, 32'h0);
        check("arst_pin", pin_o, 32'h0);
        check("arst_pin0", {24'b0, pin_o0}, 32'h0);
        rt_cyc = 1'b0;
        rt_stb = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        bus_read(4'h4, rd);
        check("arst_ren", rd, 32'h0);
        bus_read(4'h8, rd);
        check("arst_fen", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/fwgpio_in_wb.md
Name: fwgpio_in_wb

Overview:
Input-conditioning stage between the pads and the pin_i inputs of the GPIO core. It synchronises each raw pad input and debounces it with a per-pin counter. It also detects rising and falling edges and latches enabled edges into a pending register that drives a level interrupt. Software reads state and configures and clears interrupts over a Wishbone target port with a 4-bit address and 32-bit data.

Parameters:
N_PINS, 32, number of inputs (1..32).
DEB_CYCLES, 4, consecutive stable cycles required before the debounced value changes. 0 bypasses debounce.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
rt_adr  in  4  Wishbone byte address; bits [3:2] select the register
rt_dat_w  in  32  write data
rt_dat_r  out  32  read data
rt_cyc  in  1  bus cycle
rt_stb  in  1  strobe
rt_we  in  1  write enable
rt_sel  in  4  byte enables
rt_ack  out  1  acknowledge
rt_err  out  1  error (tied 0)
pad_i  in  N_PINS  raw asynchronous pad inputs
pin_o  out  N_PINS  debounced inputs, fed to the core's pin_i
irq  out  1  level interrupt, OR of PENDING

Behaviour:
Clock and reset:
- Single clock domain. One clock; reset is asynchronous and active-high.
- Reset clears every flop: sync stages, debounced state, counters, RISE_EN, FALL_EN, PENDING and the ack flop.
- Output reset values: pin_o=0, irq=0, rt_ack=0, rt_dat_r=0, rt_err=0.
- Reset mid-debounce aborts the count and loses the edge.

Synchroniser:
- Two flops per pin (s1 then s2). s2 follows pad_i 2 clocks later.

Debounce, per pin:
- Counter width is clog2(DEB_CYCLES+1).
- If s2==deb: counter clears.
- Else, if counter==DEB_CYCLES-1: deb<=s2 and counter clears.
- Else: counter increments.
- Any glitch back to deb before the threshold restarts the count.
- Net latency from pad change to pin_o is 2+DEB_CYCLES clocks.
- DEB_CYCLES=0: deb<=s2 every cycle, latency 2.
- pin_o=deb, registered.

Edge detection:
- rise = deb_next & ~deb; fall = ~deb_next & deb. Each is valid for the single cycle in which deb updates.
- Pads that are high when reset releases produce a rising edge 2+DEB_CYCLES cycles later. No interrupt results because the enables reset to 0.

Register map (word offset):
- 0x0 STATE, RO: bits [N_PINS-1:0] = pin_o; upper bits read 0. Writes are ignored.
- 0x4 RISE_EN, RW, reset 0.
- 0x8 FALL_EN, RW, reset 0.
- 0xC PENDING, RW1C, reset 0.

PENDING update:
- PENDING <= (PENDING & ~clr) | (rise & RISE_EN) | (fall & FALL_EN).
- clr is the write data masked by byte enables, on an accepted write to 0xC.
- A set and a clear of the same bit in the same cycle leaves the bit at 1 (set wins).
- An enable change takes effect for edges from the cycle after the write.
- Clearing an enable does not clear existing pending bits.

irq:
- irq = |PENDING, registered as a combinational OR of flops. It rises 1 cycle after the edge cycle.

Bus handshake:
- Access is accepted when rt_cyc & rt_stb & !rt_ack.
- rt_ack asserts for exactly 1 cycle, in the cycle after acceptance.
- Writes commit at the acceptance edge. Only bytes with rt_sel set are written.
- rt_dat_r is registered at acceptance and valid while rt_ack=1. It is 0 otherwise.
- Back-to-back strobes complete at most one access per 2 cycles.
- Bits at or above N_PINS are unwritable and read 0.
- rt_err is always 0.

Test Plan:
- Reset release with pad_i=0x0000_0005 held, DEB_CYCLES=4 -> pin_o becomes 0x5 at the 6th clock edge after release; PENDING stays 0; irq stays 0.
- Glitch: pad_i[0] high for 3 cycles, then low -> pin_o[0] stays 0 and no counter threshold is reached. Hold high for 8 cycles -> pin_o[0]=1 exactly 6 clocks after the pad rise.
- Write RISE_EN=0x1, then pulse pad_i[0] rise -> PENDING reads 0x1 and irq=1. Write 0xC with 0x1 -> PENDING=0 and irq drops the cycle after ack.
- Write FALL_EN=0x2 with rt_sel=4'b0001 -> readback 0x2. Write 0xFFFF_FFFF with rt_sel=4'b0010 -> readback 0x0000_FF02.
- A W1C of bit 0 in the same cycle as a new enabled rising edge on pin 0 -> PENDING[0] remains 1.
- DEB_CYCLES=0 build: pad toggle -> pin_o follows after 2 clocks. Assert reset while a bus read is in flight -> rt_ack=0 and rt_dat_r=0 immediately.
